cordic: RTL and testbench
=========================

CORDIC -- requirements
Module: cordic

Interface
REQ-001 SHALL have no parameters; data width is fixed at 16 bits and iteration count at 16.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 COSout  output  16  signed Q2.14 result x, registered.
REQ-005 SINout  output  16  signed Q2.14 result y, registered.
REQ-006 Xin  input  16  signed start vector x, pre-scaled by 1/K (K=1.646760); 9949 gives unit (16384) output.
REQ-007 Yin  input  16  signed start vector y, same scaling as Xin.
REQ-008 angle  input  16  signed rotation angle, radians Q2.14 (16384 = 1.0 rad; 12868 = pi/4; 25736 = pi/2).
REQ-009 SHALL use positional port order clk, COSout, SINout, Xin, Yin, angle, reset.

Function
REQ-010 SHALL rotate (Xin,Yin) by angle: COSout = K*(Xin*cos(angle) - Yin*sin(angle)), SINout = K*(Xin*sin(angle) + Yin*cos(angle)).
REQ-011 SHALL be fully pipelined: one pre-rotation stage plus 16 iteration stages, each registered.
REQ-012 Latency SHALL be 16 cycles: inputs sampled at rising edge N appear on outputs after edge N+16.
REQ-013 Throughput SHALL be one new input set accepted every cycle; no handshake, no stall.
REQ-014 Pre-rotation stage SHALL register x0=Xin, y0=Yin, z0=angle (see REQ-024 for quadrant extension).
REQ-015 Iteration i (0..15): if z>=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan_i; else x'=x+(y>>>i), y'=y-(x>>>i), z'=z+atan_i.
REQ-016 Shifts SHALL be arithmetic (sign-extending); atan_i = round(atan(2^-i)*16384).
REQ-017 atan table i=0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.
REQ-018 x, y datapath SHALL be 18-bit signed internally; z SHALL be 17-bit signed.
REQ-019 Outputs SHALL be the final-stage x, y saturated to [-32768, 32767].
REQ-020 Supported input magnitude: sqrt(Xin^2+Yin^2) <= 19896; result accuracy +/-8 LSB within that range.
REQ-021 Angle z residual after stage 15 SHALL be discarded; no angle output.

Reset
REQ-022 reset high SHALL immediately (asynchronously) clear all pipeline registers, COSout and SINout to 0.
REQ-023 After reset deassertion, outputs SHALL show results of inputs sampled from the first rising edge onward, 16 cycles later; earlier outputs are 0-derived.

Configuration
REQ-024 Macro CORDIC_QUAD_EN defined: pre-rotation SHALL apply, if angle>25736 then x0=-Yin, y0=Xin, z0=angle-25736; if angle<-25736 then x0=Yin, y0=-Xin, z0=angle+25736; full Q2.14 angle range (+/-2 rad) valid.
REQ-025 Macro CORDIC_QUAD_EN undefined: no pre-rotation; x0=Xin, y0=Yin, z0=angle; valid angle range +/-25736 only, larger angles give unspecified results.

Verification
REQ-026 Xin=9949, Yin=0, angle=12868 (45 deg) -> after 16 cycles COSout=11585+/-8, SINout=11585+/-8.
REQ-027 Xin=9949, Yin=0, angle=25736 (90 deg) -> COSout=0+/-8, SINout=16384+/-8.
REQ-028 Xin=9949, Yin=0, angle=0 then -12868 on next cycle -> consecutive outputs (16384,0) then (11585,-11585), each +/-8, back-to-back.
REQ-029 Xin=0, Yin=9949, angle=12868 -> COSout=-11585+/-8, SINout=11585+/-8.
REQ-030 With CORDIC_QUAD_EN: Xin=9949, Yin=0, angle=30000 -> COSout=-4216+/-8, SINout=15832+/-8.
REQ-031 Assert reset mid-stream between clock edges -> COSout=SINout=0 immediately; after release with angle=12868, 45-deg result appears exactly 16 edges later.

Source files
------------

// File: rtl/cordic.sv
// -----------------------------------------------------------------------------
// cordic -- fully pipelined 16-iteration CORDIC vector rotator (rotation mode).
//
// Rotates the start vector (Xin, Yin) by `angle` and delivers the CORDIC-gain
// scaled result. One new input set is accepted every cycle. Inputs sampled at
// rising edge N appear on COSout/SINout after edge N+16.
//
// Pipeline: pre-rotation register, 15 registered iterations, and a final
// iteration whose saturated x/y results are the output registers themselves.
//
// Ports (positional order):
//   clk     in   1   rising-edge clock
//   COSout  out  16  signed Q2.14 rotated x, registered, saturated
//   SINout  out  16  signed Q2.14 rotated y, registered, saturated
//   Xin     in   16  signed start x, pre-scaled by 1/K (9949 -> unit output)
//   Yin     in   16  signed start y, same scaling as Xin
//   angle   in   16  signed rotation angle, radians Q2.14 (25736 = pi/2)
//   reset   in   1   asynchronous active-high clear of all state
//
// Configuration macro: CORDIC_QUAD_EN
//   defined   : pre-rotation by +/-pi/2 extends the valid angle range to the
//               full Q2.14 range (+/-2 rad).
//   undefined : no pre-rotation; valid angle range is +/-pi/2.
// -----------------------------------------------------------------------------
module cordic (
  input  logic               clk,
  output logic signed [15:0] COSout,
  output logic signed [15:0] SINout,
  input  logic signed [15:0] Xin,
  input  logic signed [15:0] Yin,
  input  logic signed [15:0] angle,
  input  logic               reset
);

  localparam int NUM_ITER = 16;

  // x/y carry two guard bits above the 16-bit I/O to absorb CORDIC gain.
  typedef struct packed {
    logic signed [17:0] x;
    logic signed [17:0] y;
  } xy_t;

  // Index 0 holds the pre-rotated vector; index k (k >= 1) holds the result
  // of iteration k-1. Iteration 15 feeds the output registers directly.
  xy_t                xy_q [NUM_ITER];
  xy_t                xy_d [NUM_ITER];
  logic signed [16:0] z_q  [NUM_ITER];
  logic signed [16:0] z_d  [NUM_ITER];
  logic signed [15:0] cos_q, cos_d;
  logic signed [15:0] sin_q, sin_d;
  xy_t                xy_last;

  // round(atan(2^-i) * 16384)
  function automatic logic signed [16:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 17'sd12868;
      1:       atan_lut = 17'sd7596;
      2:       atan_lut = 17'sd4014;
      3:       atan_lut = 17'sd2037;
      4:       atan_lut = 17'sd1023;
      5:       atan_lut = 17'sd512;
      6:       atan_lut = 17'sd256;
      7:       atan_lut = 17'sd128;
      8:       atan_lut = 17'sd64;
      9:       atan_lut = 17'sd32;
      10:      atan_lut = 17'sd16;
      11:      atan_lut = 17'sd8;
      12:      atan_lut = 17'sd4;
      13:      atan_lut = 17'sd2;
      14:      atan_lut = 17'sd1;
      default: atan_lut = 17'sd0;
    endcase
  endfunction

  // One micro-rotation; direction follows the sign of the residual angle.
  function automatic xy_t rotate_xy(input xy_t v, input logic z_neg, input int i);
    logic signed [17:0] x, y, x_sh, y_sh;
    xy_t                r;
    x    = v.x;
    y    = v.y;
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!z_neg) begin
      r.x = x - y_sh;
      r.y = y + x_sh;
    end else begin
      r.x = x + y_sh;
      r.y = y - x_sh;
    end
    return r;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      sat16 = 16'sh7fff;
    else if (v < -18'sd32768)
      sat16 = 16'sh8000;
    else
      sat16 = v[15:0];
  endfunction

  // NOTE: every always_comb output gets a full default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    logic signed [17:0] x_ext, y_ext;
    logic signed [16:0] z_ext;

    x_ext = {{2{Xin[15]}}, Xin};
    y_ext = {{2{Yin[15]}}, Yin};
    z_ext = {angle[15], angle};

    xy_d[0].x = x_ext;
    xy_d[0].y = y_ext;
    z_d[0]    = z_ext;
`ifdef CORDIC_QUAD_EN
    // Fold angles beyond +/-pi/2 back into the convergence range with an
    // exact quarter turn before the iterations start.
    if (angle > 16'sd25736) begin
      xy_d[0].x = -y_ext;
      xy_d[0].y = x_ext;
      z_d[0]    = z_ext - 17'sd25736;
    end else if (angle < -16'sd25736) begin
      xy_d[0].x = y_ext;
      xy_d[0].y = -x_ext;
      z_d[0]    = z_ext + 17'sd25736;
    end
`endif

    for (int k = 0; k < NUM_ITER - 1; k++) begin
      xy_d[k+1] = rotate_xy(xy_q[k], z_q[k][16], k);
      z_d[k+1]  = z_q[k][16] ? (z_q[k] + atan_lut(k)) : (z_q[k] - atan_lut(k));
    end

    // Last iteration: residual angle is discarded, x/y saturate to 16 bits.
    xy_last = rotate_xy(xy_q[NUM_ITER-1], z_q[NUM_ITER-1][16], NUM_ITER - 1);
    cos_d   = sat16(xy_last.x);
    sin_d   = sat16(xy_last.y);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the pipeline arrays are real flops, not RAM, and are cleared on
      // reset so post-reset outputs are deterministic zeros.
      for (int k = 0; k < NUM_ITER; k++) begin
        xy_q[k] <= '0;
        z_q[k]  <= '0;
      end
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ITER; k++) begin
        xy_q[k] <= xy_d[k];
        z_q[k]  <= z_d[k];
      end
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign COSout = cos_q;
  assign SINout = sin_q;

endmodule

// File: tb/tb_cordic.sv
// -----------------------------------------------------------------------------
// tb_cordic -- self-checking bench for the cordic rotator.
//
// Vectors are streamed back-to-back, one per cycle; each expected result is
// queued with the cycle on which it must appear and compared when due, so a
// latency error shows up as a value mismatch between neighbouring vectors.
// Expected values are either fixed reference numbers or a real-valued model
// of K*(rotation) with saturation; tolerance is +/-8 LSB.
// -----------------------------------------------------------------------------
module tb_cordic;

  localparam real K_GAIN = 1.646760;
  localparam int  TOL    = 8;

  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] Xin   = '0;
  logic signed [15:0] Yin   = '0;
  logic signed [15:0] angle = '0;
  logic signed [15:0] COSout;
  logic signed [15:0] SINout;

  cordic dut (
    .clk    (clk),
    .COSout (COSout),
    .SINout (SINout),
    .Xin    (Xin),
    .Yin    (Yin),
    .angle  (angle),
    .reset  (reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int a;
    int ec;
    int es;
  } vec_t;

  typedef struct {
    int    due;
    int    ec;
    int    es;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act >= exp - tol && act <= exp + tol)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d +/-%0d", name, act, exp, tol);
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model(input int x, input int y, input int a, output int c, output int s);
    real th, rc, rs;
    th = real'(a) / 16384.0;
    rc = K_GAIN * (real'(x) * $cos(th) - real'(y) * $sin(th));
    rs = K_GAIN * (real'(x) * $sin(th) + real'(y) * $cos(th));
    c  = sat(int'(rc));
    s  = sat(int'(rs));
  endtask

  task automatic add_fixed(input int x, input int y, input int a, input int ec, input int es);
    vecs.push_back('{x: x, y: y, a: a, ec: ec, es: es});
  endtask

  task automatic add_model(input int x, input int y, input int a);
    int c, s;
    model(x, y, a, c, s);
    vecs.push_back('{x: x, y: y, a: a, ec: c, es: s});
  endtask

  // Compare everything due this cycle, then drive the next input set.
  task automatic step(input int x, input int y, input int a, input bit push,
                      input int ec, input int es, input string name);
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.name, "_cos"}, int'(COSout), e.ec, TOL);
      check({e.name, "_sin"}, int'(SINout), e.es, TOL);
    end
    Xin   = 16'(x);
    Yin   = 16'(y);
    angle = 16'(a);
    // Sampled at the next rising edge, visible 16 edges after that.
    if (push) sb.push_back('{due: cyc + 17, ec: ec, es: es, name: name});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(0, 0, 0, 1'b0, 0, 0, "");
    check("drain_pending", sb.size(), 0, 0);
  endtask

  initial begin
    int e_cyc;

    // Asynchronous reset: outputs clear without waiting for a clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_async_cos", int'(COSout), 0, 0);
    check("rst_async_sin", int'(SINout), 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_cos", int'(COSout), 0, 0);
    check("rst_hold_sin", int'(SINout), 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reference points, including the back-to-back 0 / -45 deg pair.
    add_fixed(9949, 0, 12868, 11585, 11585);
    add_fixed(9949, 0, 25736, 0, 16384);
    add_fixed(9949, 0, 0, 16384, 0);
    add_fixed(9949, 0, -12868, 11585, -11585);
    add_fixed(0, 9949, 12868, -11585, 11585);
    // Model-derived vectors across quadrants and angle extremes.
    add_model(5000, -7000, -20000);
    add_model(-12000, 3000, 10000);
    add_model(19896, 0, -25736);
    add_model(0, -19896, 5000);
    add_model(-9949, 0, 0);
    add_model(14000, 14000, -3000);
    // Output saturation at both rails.
    add_model(32767, 32767, 0);
    add_model(-32768, -32768, 0);
`ifdef CORDIC_QUAD_EN
    add_fixed(9949, 0, 30000, -4216, 15832);
    add_model(7000, -9000, -31000);
`endif
    for (int i = 0; i < 4; i++)
      add_model(int'($urandom_range(0, 28000)) - 14000,
                int'($urandom_range(0, 28000)) - 14000,
                int'($urandom_range(0, 51472)) - 25736);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].x, vecs[i].y, vecs[i].a, 1'b1, vecs[i].ec, vecs[i].es,
           $sformatf("vec%0d", i));
    drain();

    // Mid-stream reset: flush in-flight results, then confirm exact latency.
    for (int i = 0; i < 5; i++)
      step(vecs[i].x, vecs[i].y, vecs[i].a, 1'b0, 0, 0, "");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_cos", int'(COSout), 0, 0);
    check("rst_mid_sin", int'(SINout), 0, 0);
    sb.delete();
    @(negedge clk);
    Xin   = 16'sd9949;
    Yin   = 16'sd0;
    angle = 16'sd12868;
    e_cyc = cyc;
    #2 reset = 1'b0;
    @(negedge clk);
    Xin   = '0;
    angle = '0;
    while (cyc < e_cyc + 16) @(negedge clk);
    check("rst_pre_cos", int'(COSout), 0, 0);
    check("rst_pre_sin", int'(SINout), 0, 0);
    @(negedge clk);
    check("rst_lat_cos", int'(COSout), 11585, TOL);
    check("rst_lat_sin", int'(SINout), 11585, TOL);
    @(negedge clk);
    check("rst_post_cos", int'(COSout), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
